// File: rtl/rle_decoder_pkg.sv
// Shared definitions for the RLE pixel path. The capture-side encoder uses the
// same byte widths, so change them here only.
package rle_decoder_pkg;

  typedef enum logic [1:0] {
    S_VAL = 2'd0,
    S_CNT = 2'd1,
    S_EXP = 2'd2
  } state_t;

  localparam int COUNT_W          = 8;
  localparam int PIX_W            = 8;
  localparam int FRAME_PIXELS_DEF = 19200;

endpackage

// File: rtl/frame_addr_ctr.sv
// Framebuffer address counter: counts pixels of one frame, wrapping from
// FRAME_PIXELS-1 back to 0. It also reports whether the address it is
// about to take is the last pixel of the frame. That lets the owner register
// a frame-end flag in step with the address.
module frame_addr_ctr
  import rle_decoder_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_nxt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] addr_nxt;

  // Next address: clear wins over advance; wrap compares against the frame size, not a power of two
  always_comb begin
    addr_nxt = addr;
    if (clr) begin
      addr_nxt = '0;
    end else if (en) begin
      addr_nxt = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    end
  end

  assign last_nxt = (addr_nxt == LAST_ADDR);

  // Address register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr <= '0;
    end else begin
      addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: takes alternating VALUE/COUNT bytes from the UART side
// and expands each pair into COUNT pixels on a ready/valid stream, tagged
// with a framebuffer address that wraps once per frame.
module rle_decoder
  import rle_decoder_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_sync,
  input  logic [PIX_W-1:0]  i_byte,
  input  logic              i_valid,
  output logic              o_in_ready,
  output logic [PIX_W-1:0]  o_pix,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  input  logic              i_out_ready,
  output logic              o_frame_end,
  output logic              o_err
);

  state_t             state;
  logic [PIX_W-1:0]   value;
  logic [COUNT_W-1:0] remaining;
  logic               beat;
  logic               addr_en;
  logic               last_nxt;

  // Byte intake is open whenever a run is not being emitted
  assign o_in_ready = (state != S_EXP);
  assign beat       = o_valid & i_out_ready;
  // A beat in the same cycle as i_sync is discarded, so it must not advance the address
  assign addr_en    = beat & ~i_sync;

  frame_addr_ctr #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_W       (ADDR_W)
  ) u_addr (
    .CLK      (CLK),
    .RST      (RST),
    .en       (addr_en),
    .clr      (i_sync),
    .addr     (o_addr),
    .last_nxt (last_nxt)
  );

  // Decoder FSM with registered stream outputs; i_sync overrides everything else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_VAL;
      value       <= '0;
      remaining   <= '0;
      o_pix       <= '0;
      o_valid     <= 1'b0;
      o_frame_end <= 1'b0;
      o_err       <= 1'b0;
    end else if (i_sync) begin
      state       <= S_VAL;
      remaining   <= '0;
      o_valid     <= 1'b0;
      o_frame_end <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        S_VAL: begin
          if (i_valid) begin
            value <= i_byte;
            state <= S_CNT;
          end
        end
        S_CNT: begin
          if (i_valid) begin
            if (i_byte != '0) begin
              remaining   <= i_byte;
              o_pix       <= value;
              o_valid     <= 1'b1;
              o_frame_end <= last_nxt;
              state       <= S_EXP;
            end else begin
              // A zero count is malformed; flag it and drop the pair
              o_err <= 1'b1;
              state <= S_VAL;
            end
          end
        end
        S_EXP: begin
          if (i_out_ready) begin
            remaining <= remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) begin
              o_valid     <= 1'b0;
              o_frame_end <= 1'b0;
              state       <= S_VAL;
            end else begin
              o_frame_end <= last_nxt;
            end
          end
        end
        default: begin
          state   <= S_VAL;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
module tb_rle_decoder;

  localparam int FP = 19200;
  localparam int AW = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          i_sync = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_valid = 1'b0;
  logic          i_out_ready = 1'b1;
  logic          o_in_ready;
  logic [7:0]    o_pix;
  logic [AW-1:0] o_addr;
  logic          o_valid;
  logic          o_frame_end;
  logic          o_err;

  rle_decoder #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_sync      (i_sync),
    .i_byte      (i_byte),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .o_pix       (o_pix),
    .o_addr      (o_addr),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_frame_end (o_frame_end),
    .o_err       (o_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]    pix;
    logic [AW-1:0] addr;
    logic          fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beats = 0;
  int   cyc = 0;
  int   exp_addr = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: a beat is committed at the next rising edge when valid and ready are both high
  always @(negedge CLK) begin
    if (RST && !i_sync && o_valid) begin
      checks++;
      if (o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_during_run got %b want 0", o_in_ready);
      end
      if (i_out_ready) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got pix=%h addr=%0d want no beat", o_pix, o_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({o_pix, o_addr, o_frame_end} !== e) begin
            errors++;
            $display("FAIL beat got pix=%h addr=%0d fe=%b want pix=%h addr=%0d fe=%b",
                     o_pix, o_addr, o_frame_end, e.pix, e.addr, e.fe);
          end
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_run(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pix  = v;
      e.addr = AW'(exp_addr);
      e.fe   = (exp_addr == FP - 1);
      exp_q.push_back(e);
      exp_addr = (exp_addr + 1) % FP;
    end
  endtask

  // Offers one byte and returns one time unit after the edge that accepted it
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int n;
    n = 0;
    i_byte  = b;
    i_valid = 1'b1;
    forever begin
      @(negedge CLK);
      rdy = o_in_ready;
      @(posedge CLK);
      #1;
      if (rdy) break;
      n++;
      if (n > 2000) begin
        $display("FAIL send_byte_timeout got ready=0 want ready=1");
        $fatal(1, "byte never accepted");
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] v, input logic [7:0] c);
    push_run(v, int'(c));
    send_byte(v);
    send_byte(c);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!o_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_sync();
    i_sync = 1'b1;
    @(posedge CLK);
    #1;
    i_sync = 1'b0;
    exp_q.delete();
    exp_addr = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({o_in_ready, o_valid, o_pix, o_addr, o_frame_end, o_err} !== {1'b1, 1'b0, 8'h00, 15'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b pix=%h addr=%0d fe=%b err=%b want 1 0 00 0 0 0",
               o_in_ready, o_valid, o_pix, o_addr, o_frame_end, o_err);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got rdy=%b vld=%b want 1 0", o_in_ready, o_valid);
    end
  endtask

  task automatic test_basic();
    do_sync();
    send_pair(8'h2A, 8'd3);
    checks++;
    if (o_valid !== 1'b1 || o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got vld=%b rdy=%b want 1 0", o_valid, o_in_ready);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || exp_q.size() != 0 || o_addr !== 15'd3) begin
      errors++;
      $display("FAIL basic_end got vld=%b rdy=%b pending=%0d addr=%0d want 0 1 0 3",
               o_valid, o_in_ready, exp_q.size(), o_addr);
    end
  endtask

  task automatic test_stall();
    logic [24:0] snap;
    int b0;
    bit ok;
    do_sync();
    b0 = beats;
    i_out_ready = 1'b0;
    send_pair(8'h10, 8'd2);
    snap = {o_valid, o_pix, o_addr, o_frame_end};
    checks++;
    if (snap !== {1'b1, 8'h10, 15'd0, 1'b0}) begin
      errors++;
      $display("FAIL stall_first got %h want %h", snap, {1'b1, 8'h10, 15'd0, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({o_valid, o_pix, o_addr, o_frame_end} !== snap || o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got %h rdy=%b want %h rdy=0",
                 {o_valid, o_pix, o_addr, o_frame_end}, o_in_ready, snap);
      end
    end
    i_out_ready = 1'b1;
    send_pair(8'h20, 8'd1);
    wait_idle(100, ok);
    checks++;
    if (!ok || beats - b0 != 3) begin
      errors++;
      $display("FAIL stall_stream got idle=%b beats=%0d want 1 3", ok, beats - b0);
    end
  endtask

  task automatic test_frame_wrap();
    bit ok;
    do_sync();
    for (int k = 0; k < 75; k++) send_pair(8'(k), 8'd255);
    send_pair(8'hC3, 8'd73);
    checks++;
    if (exp_addr != FP - 2) begin
      errors++;
      $display("FAIL frame_preload got %0d want %0d", exp_addr, FP - 2);
    end
    send_pair(8'h55, 8'd4);
    wait_idle(2000, ok);
    checks++;
    if (!ok || o_addr !== 15'd2) begin
      errors++;
      $display("FAIL frame_wrap_end got idle=%b addr=%0d want 1 2", ok, o_addr);
    end
  endtask

  task automatic test_err();
    int b0;
    bit ok;
    do_sync();
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_initial got %b want 0", o_err);
    end
    b0 = beats;
    send_pair(8'h77, 8'd0);
    checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_zero_count got err=%b vld=%b rdy=%b want 1 0 1", o_err, o_valid, o_in_ready);
    end
    send_pair(8'h33, 8'd1);
    wait_idle(100, ok);
    checks++;
    if (!ok || o_err !== 1'b1 || beats - b0 != 1) begin
      errors++;
      $display("FAIL err_sticky got idle=%b err=%b beats=%0d want 1 1 1", ok, o_err, beats - b0);
    end
    do_sync();
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_sync got %b want 0", o_err);
    end
  endtask

  task automatic test_max_run();
    int b0;
    do_sync();
    b0 = beats;
    send_pair(8'hFF, 8'hFF);
    repeat (255) @(posedge CLK);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || beats - b0 != 255 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_run got vld=%b rdy=%b beats=%0d pending=%0d want 0 1 255 0",
               o_valid, o_in_ready, beats - b0, exp_q.size());
    end
  endtask

  task automatic test_sync_mid();
    bit ok;
    do_sync();
    send_pair(8'hAB, 8'd10);
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 5) begin
      errors++;
      $display("FAIL sync_pre_count got %0d want 5", exp_q.size());
    end
    i_sync = 1'b1;
    @(posedge CLK);
    #1;
    i_sync = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_addr !== 15'd0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sync_abort got vld=%b addr=%0d rdy=%b want 0 0 1", o_valid, o_addr, o_in_ready);
    end
    exp_q.delete();
    exp_addr = 0;
    send_pair(8'h01, 8'd1);
    wait_idle(100, ok);
    checks++;
    if (!ok || o_addr !== 15'd1) begin
      errors++;
      $display("FAIL sync_resume got idle=%b addr=%0d want 1 1", ok, o_addr);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    do_sync();
    send_pair(8'h77, 8'd0);
    send_pair(8'hAB, 8'd10);
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_addr, o_in_ready, o_err, o_pix, o_frame_end} !== {1'b0, 15'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_async got vld=%b addr=%0d rdy=%b err=%b pix=%h fe=%b want 0 0 1 0 00 0",
               o_valid, o_addr, o_in_ready, o_err, o_pix, o_frame_end);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    exp_q.delete();
    exp_addr = 0;
    send_pair(8'h01, 8'd1);
    wait_idle(100, ok);
    checks++;
    if (!ok || o_addr !== 15'd1) begin
      errors++;
      $display("FAIL rst_resume got idle=%b addr=%0d want 1 1", ok, o_addr);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    bit ok;
    do_sync();
    c0 = cyc;
    send_pair(8'h01, 8'd1);
    send_pair(8'h02, 8'd2);
    send_pair(8'h03, 8'd3);
    send_pair(8'h04, 8'd4);
    wait_idle(100, ok);
    checks++;
    if (!ok || cyc - c0 != 18) begin
      errors++;
      $display("FAIL back_to_back_cycles got idle=%b cycles=%0d want 1 18", ok, cyc - c0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_max_run();
    test_sync_mid();
    test_rst_mid();
    test_back_to_back();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Expands the run-length byte stream produced by the capture-side RLE encoder back into individual 8-bit pixels. It sits between the UART receiver and the VGA framebuffer writer. Input arrives as alternating VALUE and COUNT bytes. Output is a ready/valid pixel stream with a framebuffer write address that wraps once per frame.

## Interface
- FRAME_PIXELS, 19200, pixels per frame (160×120); address wraps to 0 after FRAME_PIXELS-1
- ADDR_W, 15, width of o_addr; must satisfy 2^ADDR_W ≥ FRAME_PIXELS
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- i_sync  in  1  synchronous resynchronise: abort the current pair/run, return to S_VAL, zero the address, clear o_err
- i_byte  in  8  input byte (VALUE or COUNT, by position)
- i_valid  in  1  i_byte valid
- o_in_ready  out  1  decoder accepts a byte this cycle
- o_pix  out  8  output pixel value
- o_addr  out  ADDR_W  framebuffer address of o_pix
- o_valid  out  1  o_pix/o_addr valid
- i_out_ready  in  1  downstream accepts a pixel
- o_frame_end  out  1  high with the beat whose o_addr = FRAME_PIXELS-1
- o_err  out  1  sticky; set when a COUNT byte of 0 is received

## Operation
- FSM states:
  - S_VAL: waiting for a VALUE byte
  - S_CNT: waiting for a COUNT byte
  - S_EXP: emitting a run
- o_in_ready = 1 in S_VAL and S_CNT, 0 in S_EXP. A byte is accepted when i_valid && o_in_ready.
- S_VAL, byte accepted: latch the value register, go to S_CNT.
- S_CNT, byte accepted:
  - If byte ≠ 0: load remaining = byte, go to S_EXP.
  - If byte = 0: set o_err, emit nothing, go to S_VAL.
- S_EXP:
  - o_valid = 1; o_pix = latched value; o_addr = address counter.
  - A beat occurs when o_valid && i_out_ready.
  - On each beat: remaining decrements; address increments, wrapping FRAME_PIXELS-1 → 0.
  - On the beat where remaining = 1: go to S_VAL.
- Holding rule: while i_out_ready = 0, o_pix, o_addr, o_valid and o_frame_end hold stable.
- Width rules:
  - remaining is 8 bits; maximum run is 255.
  - Address compare is against the constant FRAME_PIXELS-1, not a power of two.
- A run crossing the frame end continues from address 0 with no gap. o_frame_end fires on the FRAME_PIXELS-1 beat only.
- i_sync takes priority over all events in the same cycle. The byte and beat offered that cycle are discarded.
- Reset values: state S_VAL, o_in_ready 1, o_valid 0, o_pix 0, o_addr 0, o_frame_end 0, o_err 0, remaining 0.

## Timing
- o_in_ready is combinational from state. All other outputs are registered.
- COUNT byte accepted in cycle t → o_valid = 1 in cycle t+1.
- Last beat in cycle u → o_valid = 0 and o_in_ready = 1 in cycle u+1.
- Steady-state throughput with downstream always ready: a run of N pixels costs N+2 cycles (two byte cycles plus N beats).
- Back-to-back bytes are accepted in S_VAL→S_CNT on consecutive cycles.
- RST deassertion mid-run: decoding restarts in S_VAL with address 0. Partial run output is not resumed.
- o_frame_end is valid only while o_valid = 1.

## Structure
- Shared package holds:
  - state encoding constants S_VAL, S_CNT, S_EXP
  - COUNT width (8) and PIX_W (8), shared with the RLE encoder
  - default FRAME_PIXELS
- Natural sub-module: `frame_addr_ctr` (enable, sync clear, wrap at FRAME_PIXELS, last-pixel flag). It is reusable by the VGA scan-out side.
- FSM, value register and remaining counter stay in the top module.

## Test plan
- Bytes 0x2A,0x03 with i_out_ready=1 → three beats, o_pix 0x2A at o_addr 0,1,2; o_valid low the next cycle; o_in_ready high again.
- Bytes 0x10,0x02 then 0x20,0x01, with i_out_ready low for 4 cycles on the first beat → outputs hold stable while stalled; then stream 0x10@0, 0x10@1, 0x20@2; o_in_ready = 0 throughout S_EXP.
- Preload address to FRAME_PIXELS-2, send 0x55,0x04 → addresses 19198, 19199, 0, 1; o_frame_end high only on 19199.
- Bytes 0x77,0x00 then 0x33,0x01 → no output for the first pair; o_err = 1 and sticky; single beat 0x33; o_err clears only on i_sync or RST.
- Run 0xFF,0xFF (255 beats) → exactly 255 beats, remaining never wraps, return to S_VAL.
- i_sync asserted mid-run after 5 of 10 beats → next cycle o_valid = 0, S_VAL, o_addr = 0; a following pair 0x01,0x01 emits at address 0. RST mid-run behaves identically, asynchronously.
